mac_pipe_param: RTL and testbench
=================================

// Module: mac_pipe_param
// PURPOSE
//  Parametrised, pipelined multiply-accumulate: Product = X*Y + Z, low WIDTH bits, with overflow flag.
//  Successor to the fixed 32x32 Booth/Wallace MAC: generic width, configurable depth, per-op signed/unsigned mode.
//  Valid/ready handshakes on both sides allow back-pressure.
//  Sits between the operand register file and the result writeback in the compute datapath.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; even, >= 8
//  STAGES  3   pipeline depth = input-to-output latency in cycles; 1..6
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts a beat this cycle
//  in_signed  in   1      1: two's-complement operands; 0: unsigned
//  X          in   WIDTH  multiplicand
//  Y          in   WIDTH  multiplier
//  Z          in   WIDTH  addend
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts the result
//  Product    out  WIDTH  (X*Y+Z)[WIDTH-1:0], or saturated (see CONFIGURATION)
//  Ovfl       out  1      exact X*Y+Z is not representable in WIDTH bits in the selected mode
// BEHAVIOUR
//  - Reset: clears all stage valid bits. out_valid=0, Product=0, Ovfl=0. in_ready=1 in the first cycle after reset.
//  - Reset mid-operation: all in-flight beats are discarded. No partial result is ever emitted.
//  - Accept: beat accepted when in_valid && in_ready. Result accepted when out_valid && out_ready.
//  - Stall rule: adv = !out_valid || out_ready. in_ready = adv (combinational).
//    When adv=0, every stage holds, including data, mode and valid.
//  - Pipeline: one valid bit per stage, STAGES registers in total.
//  - Latency: a beat accepted in cycle N appears in cycle N+STAGES when there is no stall.
//    Throughput: 1 beat/cycle.
//  - Bubbles: when in_valid=0 and adv=1, stage 0 loads valid=0.
//    Bubbles advance through the pipe, so there is no gap compression.
//  - Data path:
//    - Internally X, Y and Z extend to 2*WIDTH+1 bits: sign-extended if in_signed, zero-extended otherwise.
//    - The exact sum S = X*Y + Z is computed.
//    - The implementation may split the multiply (Booth partial products, CSA tree, final add) across stages.
//    - Only the final stage's registered outputs are architecturally visible.
//  - Overflow:
//    - signed: Ovfl=1 iff S < -2^(WIDTH-1) or S > 2^(WIDTH-1)-1
//    - unsigned: Ovfl=1 iff S > 2^WIDTH-1
//  - Outputs: Product and Ovfl are registered. They stay stable while out_valid=1 and out_ready=0.
//    They hold their last value when out_valid=0.
//  - Mode: in_signed travels with its beat, so mixed-mode back-to-back beats are legal.
//  - Simultaneous accept and output: with a full pipe and out_ready=1, one beat leaves and one enters in the same cycle.
// CONFIGURATION
//  MAC_SATURATE_EN defined:
//    - On Ovfl=1, Product clamps to the bound of the selected mode:
//      - signed: 2^(WIDTH-1)-1 if S>0, else -2^(WIDTH-1)
//      - unsigned: 2^WIDTH-1
//    - Ovfl still asserts.
//  MAC_SATURATE_EN undefined:
//    - Product = S[WIDTH-1:0] (wrap-around). Ovfl is unchanged.
// TESTING (WIDTH=32, STAGES=3 unless noted)
//  1. Basic: reset 2 cycles, then X=7, Y=6, Z=3, unsigned, out_ready=1.
//     -> out_valid exactly 3 cycles after accept; Product=45, Ovfl=0.
//  2. Signed: X=-5 (32'hFFFFFFFB), Y=4, Z=1, in_signed=1.
//     -> Product=32'hFFFFFFED (-19), Ovfl=0. Same operands with in_signed=0 -> Ovfl=1.
//  3. Overflow/saturate: X=Y=32'h00010000, Z=0, unsigned.
//     -> Ovfl=1. Product=0 without MAC_SATURATE_EN; 32'hFFFFFFFF with it.
//  4. Back-pressure: stream 8 beats i=1..8 (X=i, Y=i, Z=0); out_ready=0 for cycles 4-7.
//     -> in_ready=0 while the head is stalled; outputs 1,4,9,...,64 in order; none lost or duplicated.
//  5. Reset mid-flight: accept 2 beats, assert reset 1 cycle.
//     -> out_valid stays 0; neither beat ever appears.
//  6. Sweep: STAGES=1 and 6, WIDTH=16.
//     -> latency equals STAGES; 10k random beats with random ready match the reference model (Product, Ovfl).

Source files
------------

// File: rtl/mac_pipe_param_if.sv
// Operand and result handshake bundle for mac_pipe_param.
// master drives operands and out_ready; slave is the MAC itself.
interface mac_pipe_param_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             in_signed;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] Z;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Product;
   logic             Ovfl;

   modport master (
      output in_valid, in_signed, X, Y, Z, out_ready,
      input  in_ready, out_valid, Product, Ovfl
   );

   modport slave (
      input  in_valid, in_signed, X, Y, Z, out_ready,
      output in_ready, out_valid, Product, Ovfl
   );
endinterface

// File: rtl/mac_pipe_param.sv
// Pipelined X*Y+Z (signed/unsigned per beat) with overflow flag; MAC_SATURATE_EN clamps on overflow.
// Latency STAGES cycles, 1 beat/cycle; in_ready = !out_valid || out_ready, whole pipe holds on stall.
module mac_pipe_param #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 3
) (
   input logic             clock,
   input logic             reset,
   mac_pipe_param_if.slave bus
);
   localparam int XW       = 2*WIDTH + 1;
   localparam int PP_STAGE = (STAGES >= 3) ? 1 : 0;

   // Slots a/b/c carry extended X/Y/Z until the partial-product step, then pp_lo/pp_hi/Z.
   typedef struct packed {
      logic          vld;
      logic          sgn;
      logic [XW-1:0] a;
      logic [XW-1:0] b;
      logic [XW-1:0] c;
   } stage_t;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             ovf;
   } result_t;

   function automatic logic [XW-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
      return {{(WIDTH+1){sgn & v[WIDTH-1]}}, v};
   endfunction

   // Split Y at bit WIDTH; everything is exact modulo 2^XW, which holds the full signed sum.
   function automatic stage_t partial_products(input stage_t s);
      stage_t r;
      r   = s;
      r.a = s.a * {{(WIDTH+1){1'b0}}, s.b[WIDTH-1:0]};
      r.b = (s.a * {{WIDTH{1'b0}}, s.b[XW-1:WIDTH]}) << WIDTH;
      return r;
   endfunction

   function automatic result_t final_sum(input logic [XW-1:0] a,
                                         input logic [XW-1:0] b,
                                         input logic [XW-1:0] c,
                                         input logic          sgn);
      logic [XW-1:0] s;
      result_t       r;
      s = a + b + c;
      if (sgn) begin
         r.ovf = !((&s[XW-1:WIDTH-1]) || !(|s[XW-1:WIDTH-1]));
      end else begin
         r.ovf = |s[XW-1:WIDTH];
      end
      r.res = s[WIDTH-1:0];
`ifdef MAC_SATURATE_EN
      if (r.ovf) begin
         r.res = sgn ? {s[XW-1], {(WIDTH-1){~s[XW-1]}}} : {WIDTH{1'b1}};
      end
`endif
      return r;
   endfunction

   stage_t           beat_in;
   logic             adv;
   logic             out_vld_q;
   logic [WIDTH-1:0] res_q;
   logic             ovf_q;

   assign adv           = !out_vld_q || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_vld_q;
   assign bus.Product   = res_q;
   assign bus.Ovfl      = ovf_q;

   always_comb begin
      beat_in.vld = bus.in_valid;
      beat_in.sgn = bus.in_signed;
      beat_in.a   = extend(bus.X, bus.in_signed);
      beat_in.b   = extend(bus.Y, bus.in_signed);
      beat_in.c   = extend(bus.Z, bus.in_signed);
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t src;
      stage_t nxt;

      if (k == 0) begin : g_src
         assign src = beat_in;
      end else begin : g_src
         assign src = g_stage[k-1].g_reg.q;
      end

      always_comb begin
         nxt = src;
         if (k == PP_STAGE) begin
            nxt = partial_products(nxt);
         end
      end

      if (k < STAGES-1) begin : g_reg
         stage_t q;

         // Data only loads with a valid beat; bubbles move just the valid bit.
         always_ff @(posedge clock) begin
            if (reset) begin
               q.vld <= 1'b0;
            end else if (adv) begin
               q.vld <= nxt.vld;
               if (nxt.vld) begin
                  q <= nxt;
               end
            end
         end
      end else begin : g_out
         result_t fin;

         always_comb begin
            fin = final_sum(nxt.a, nxt.b, nxt.c, nxt.sgn);
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               out_vld_q <= 1'b0;
               res_q     <= '0;
               ovf_q     <= 1'b0;
            end else if (adv) begin
               out_vld_q <= nxt.vld;
               if (nxt.vld) begin
                  res_q <= fin.res;
                  ovf_q <= fin.ovf;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_mac_pipe_param.sv
// Scoreboard bench for mac_pipe_param: directed cases plus random beats against an exact-arithmetic model.
module tb_mac_pipe_param;
   localparam int WIDTH  = 32;
   localparam int STAGES = 3;

   typedef struct {
      logic [WIDTH-1:0] prod;
      logic             ovf;
      int               acc_cyc;
      bit               lat;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   mac_pipe_param_if #(.WIDTH(WIDTH)) bus();
   mac_pipe_param #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   rdy_mode = 0;    // 0: always ready, 1: random, 2: stall profile
   int   prof_k = 0;
   int   ready_low_cnt = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Exact X*Y+Z in wide signed arithmetic, then range tests against the mode's bounds.
   function automatic exp_t model(input logic [WIDTH-1:0] x, y, z, input logic sgn);
      logic signed [127:0] xs, ys, zs, s, lo, hi;
      exp_t e;
      if (sgn) begin
         xs = signed'(x); ys = signed'(y); zs = signed'(z);
         lo = -(128'sd1 <<< (WIDTH-1));
         hi = (128'sd1 <<< (WIDTH-1)) - 1;
      end else begin
         xs = {{(128-WIDTH){1'b0}}, x}; ys = {{(128-WIDTH){1'b0}}, y}; zs = {{(128-WIDTH){1'b0}}, z};
         lo = 0;
         hi = (128'sd1 <<< WIDTH) - 1;
      end
      s = xs * ys + zs;
      e.ovf  = (s < lo) || (s > hi);
      e.prod = s[WIDTH-1:0];
`ifdef MAC_SATURATE_EN
      if (e.ovf) e.prod = (s > hi) ? hi[WIDTH-1:0] : lo[WIDTH-1:0];
`endif
      e.acc_cyc = 0;
      e.lat     = 1'b0;
      return e;
   endfunction

   function automatic logic [WIDTH-1:0] rnd_op();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
         0: return WIDTH'($urandom_range(0, 15));
         1: return {WIDTH{1'b1}};
         2: return {1'b1, {(WIDTH-1){1'b0}}};
         3: return {1'b0, {(WIDTH-1){1'b1}}};
         default: return r[WIDTH-1:0];
      endcase
   endfunction

   task automatic chk_vec(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic send(input logic [WIDTH-1:0] x, y, z, input logic sgn, input bit lat);
      int   waitc = 0;
      exp_t e;
      @(negedge clock);
      bus.in_valid = 1'b1; bus.in_signed = sgn;
      bus.X = x; bus.Y = y; bus.Z = z;
      forever begin
         #1;
         if (bus.in_ready) begin
            e = model(x, y, z, sgn);
            e.acc_cyc = cyc;
            e.lat = lat;
            sbq.push_back(e);
            break;
         end
         waitc++;
         if (waitc > 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1 within 200", waitc);
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clock);
      bus.in_valid = 1'b0;
      while (sbq.size() != 0 && n < 1000) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d beats outstanding after %0d cycles, required 0", sbq.size(), n);
      end
      repeat (STAGES + 2) @(negedge clock);
   endtask

   always @(negedge clock) begin
      case (rdy_mode)
         0: begin bus.out_ready = 1'b1; prof_k = 0; end
         1: begin bus.out_ready = ($urandom_range(0, 3) != 0); prof_k = 0; end
         default: begin
            bus.out_ready = !(prof_k >= 4 && prof_k <= 7);
            prof_k++;
         end
      endcase
   end

   // Monitor: handshake rule, hold/stability, and in-order scoreboard compare.
   logic             have_prev = 1'b0;
   logic             prev_vld, prev_rdy, prev_ovf;
   logic [WIDTH-1:0] prev_prod;
   exp_t             got;
   always @(negedge clock) begin
      #2;
      if (reset) begin
         have_prev = 1'b0;
      end else begin
         chk_bit("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
         if (!bus.in_ready) ready_low_cnt++;
         if (have_prev) begin
            if (prev_vld && !prev_rdy) begin
               chk_bit("stall_valid", bus.out_valid, 1'b1);
               chk_vec("stall_product", bus.Product, prev_prod);
               chk_bit("stall_ovfl", bus.Ovfl, prev_ovf);
            end else if (!prev_vld && !bus.out_valid) begin
               chk_vec("idle_product_hold", bus.Product, prev_prod);
               chk_bit("idle_ovfl_hold", bus.Ovfl, prev_ovf);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output: Product=%h Ovfl=%b with no beat outstanding", bus.Product, bus.Ovfl);
            end else begin
               got = sbq.pop_front();
               chk_vec("product", bus.Product, got.prod);
               chk_bit("ovfl", bus.Ovfl, got.ovf);
               if (got.lat) chk_int("latency", cyc - got.acc_cyc, STAGES);
            end
         end
         prev_vld  = bus.out_valid;
         prev_rdy  = bus.out_ready;
         prev_prod = bus.Product;
         prev_ovf  = bus.Ovfl;
         have_prev = 1'b1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int low_before;
      bus.in_valid = 1'b0; bus.in_signed = 1'b0;
      bus.X = '0; bus.Y = '0; bus.Z = '0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #3;
      chk_bit("reset_out_valid", bus.out_valid, 1'b0);
      chk_vec("reset_product", bus.Product, '0);
      chk_bit("reset_ovfl", bus.Ovfl, 1'b0);
      chk_bit("reset_in_ready", bus.in_ready, 1'b1);

      // Basic, signed/unsigned pair, overflow cases (latency checked on all)
      send(7, 6, 3, 1'b0, 1'b1);
      drain();
      send(32'hFFFFFFFB, 4, 1, 1'b1, 1'b1);
      send(32'hFFFFFFFB, 4, 1, 1'b0, 1'b1);
      send(32'h00010000, 32'h00010000, 0, 1'b0, 1'b1);
      send(32'h7FFFFFFF, 32'h7FFFFFFF, 0, 1'b1, 1'b1);
      send(32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1);
      send(32'h80000000, 1, 32'hFFFFFFFF, 1'b1, 1'b1);
      send(32'h7FFFFFFF, 1, 1, 1'b1, 1'b1);
      send(32'hFFFFFFFF, 1, 1, 1'b0, 1'b1);
      send(32'hFFFFFFFF, 1, 0, 1'b0, 1'b1);
      drain();

      // Back-pressure: 8 beats with out_ready low for cycles 4-7
      low_before = ready_low_cnt;
      @(posedge clock);
      rdy_mode = 2;
      for (int i = 1; i <= 8; i++) send(WIDTH'(i), WIDTH'(i), 0, 1'b0, 1'b0);
      drain();
      rdy_mode = 0;
      checks++;
      if (ready_low_cnt == low_before) begin
         errors++;
         $display("FAIL backpressure_in_ready: in_ready low cycles got 0, required >0");
      end

      // Reset mid-flight discards in-flight beats
      send(3, 3, 3, 1'b0, 1'b0);
      send(5, 5, 5, 1'b1, 1'b0);
      @(negedge clock);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      sbq.delete();
      @(negedge clock);
      reset = 1'b0;
      #3;
      chk_vec("midreset_product", bus.Product, '0);
      chk_bit("midreset_ovfl", bus.Ovfl, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         #3;
         chk_bit("midreset_no_output", bus.out_valid, 1'b0);
      end

      // Random beats, always-ready (latency checked), then random ready
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
         send(rnd_op(), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'b1);
      end
      drain();
      rdy_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 4) == 0) idle(1 + $urandom_range(0, 2));
         send(rnd_op(), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'b0);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
